ex_stage_mdu: RTL and testbench

- Parametrised successor of the pipeline EX stage.
- Contains the register-operand ALU, two-source operand forwarding (MEM, then WB), and the RT/RD destination mux.
- Owns the EX/MEM pipeline register.
- Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers and MFHI/MFLO, plus a stall handshake toward ID.

---
 rtl/ex_pkg.sv | 40 ++++
 rtl/mdu_iter.sv | 109 ++++++++++
 rtl/ex_stage_mdu.sv | 112 +++++++++++
 tb/tb_ex_stage_mdu.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU/MDU control types, funct codes and decode helpers for the EX stage.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_MFHI, ALU_MFLO, ALU_NONE
    } alu_ctrl_e;

    typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;

    typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;

    function automatic alu_ctrl_e decode_funct(input logic [5:0] fn);
        return fn == FN_ADD  ? ALU_ADD  :
               fn == FN_SUB  ? ALU_SUB  :
               fn == FN_AND  ? ALU_AND  :
               fn == FN_OR   ? ALU_OR   :
               fn == FN_NOR  ? ALU_NOR  :
               fn == FN_SLT  ? ALU_SLT  :
               fn == FN_MFHI ? ALU_MFHI :
               fn == FN_MFLO ? ALU_MFLO : ALU_NONE;
    endfunction

    function automatic logic is_mdu_funct(input logic [5:0] fn);
        return fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative multiply/divide with HI/LO; op[1]=divide, op[0]=unsigned.
// EX_MDU_FAST_MUL_EN makes multiplies complete in the issue cycle.
module mdu_iter
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdu_state_e        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              is_div, neg_a, neg_b, b_zero;
    logic              sa, sb, fast, start_ok, last;
    logic [XLEN-1:0]   raw_a, mb, r, q, r_nx, q_nx;
    logic [XLEN-1:0]   abs_a, abs_b, div_lo, div_hi;
    logic [XLEN:0]     add_s;
    logic [XLEN+1:0]   sub_d;
    logic [2*XLEN-1:0] prod, mul_res, fast_res;

    assign sa    = ~op[0] & a[XLEN-1];
    assign sb    = ~op[0] & b[XLEN-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;

`ifdef EX_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag;
    assign fast     = ~op[1];
    assign fast_mag = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
    assign fast_res = (sa ^ sb) ? -fast_mag : fast_mag;
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    assign busy     = state == MDU_BUSY;
    assign start_ok = start & ~busy;
    assign last     = busy & (cnt == CNT_W'(1));

    // Multiply shifts {r,q} right adding mb; divide shifts left, subtracting mb when it fits.
    assign add_s = {1'b0, r} + (q[0] ? {1'b0, mb} : '0);
    assign sub_d = {1'b0, r, q[XLEN-1]} - {2'b0, mb};

    always_comb begin
        r_nx = is_div ? (sub_d[XLEN+1] ? {r[XLEN-2:0], q[XLEN-1]} : sub_d[XLEN-1:0]) : add_s[XLEN:1];
        q_nx = is_div ? {q[XLEN-2:0], ~sub_d[XLEN+1]} : {add_s[0], q[XLEN-1:1]};
    end

    assign prod    = {r_nx, q_nx};
    assign mul_res = (neg_a ^ neg_b) ? -prod : prod;
    assign div_lo  = b_zero ? '1 : (neg_a ^ neg_b) ? -q_nx : q_nx;
    assign div_hi  = b_zero ? raw_a : neg_a ? -r_nx : r_nx;

    always_comb begin
        state_nx = busy ? (last ? MDU_IDLE : MDU_BUSY) : (start_ok & ~fast ? MDU_BUSY : MDU_IDLE);
        cnt_nx   = busy ? cnt - 1'b1 : (start_ok & ~fast ? CNT_W'(XLEN) : cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r      <= '0;
            q      <= '0;
            mb     <= '0;
            raw_a  <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (start_ok && fast) begin
            {hi, lo} <= fast_res;
        end else if (start_ok) begin
            r      <= '0;
            q      <= abs_a;
            mb     <= abs_b;
            raw_a  <= a;
            is_div <= op[1];
            neg_a  <= sa;
            neg_b  <= sb;
            b_zero <= b == '0;
        end else if (busy) begin
            r <= r_nx;
            q <= q_nx;
            if (last)
                {hi, lo} <= is_div ? {div_hi, div_lo} : mul_res;
        end
    end

endmodule

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: EX stage with ALU, MEM/WB forwarding, EX/MEM register and iterative MDU.
// Define EX_MDU_FAST_MUL_EN for single-cycle MULT/MULTU.
module ex_stage_mdu
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            flush_i,
    input  logic [XLEN-1:0] data_1,
    input  logic [XLEN-1:0] data_2,
    input  logic [XLEN-1:0] imm,
    input  logic [RAW-1:0]  rs,
    input  logic [RAW-1:0]  rt,
    input  logic [RAW-1:0]  rd,
    input  logic [1:0]      alu_op,
    input  logic            alu_src,
    input  logic            reg_dst,
    input  logic [2:0]      m_ex,
    input  logic [1:0]      wb_ex,
    input  logic [RAW-1:0]  rd_wb,
    input  logic            reg_write_wb,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_o,
    output logic            valid_q,
    output logic [XLEN-1:0] res_q,
    output logic            zero_q,
    output logic [RAW-1:0]  write_reg_q,
    output logic [XLEN-1:0] store_data_q,
    output logic [2:0]      m_q,
    output logic [1:0]      wb_q,
    output logic            mdu_busy_o
);

    logic [5:0]      funct;
    alu_ctrl_e       ctrl;
    fwd_sel_e        sel_a, sel_b;
    logic            mem_fwd, wb_fwd, is_mdu, is_mf, bubble, keep, slt;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b, res, hi, lo;
    logic [RAW-1:0]  dst;

    assign funct = imm[5:0];

    // Register 0 is never a forwarding source.
    assign mem_fwd = valid_q & wb_q[0] & |write_reg_q;
    assign wb_fwd  = reg_write_wb & |rd_wb;
    assign sel_a   = mem_fwd && write_reg_q == rs ? FWD_MEM : wb_fwd && rd_wb == rs ? FWD_WB : FWD_REG;
    assign sel_b   = mem_fwd && write_reg_q == rt ? FWD_MEM : wb_fwd && rd_wb == rt ? FWD_WB : FWD_REG;
    assign fwd_a   = sel_a == FWD_MEM ? res_q : sel_a == FWD_WB ? wb_data : data_1;
    assign fwd_b   = sel_b == FWD_MEM ? res_q : sel_b == FWD_WB ? wb_data : data_2;
    assign op_b    = alu_src ? imm : fwd_b;
    assign dst     = reg_dst ? rd : rt;

    assign ctrl   = alu_op == 2'd0 ? ALU_ADD : alu_op == 2'd1 ? ALU_SUB :
                    alu_op == 2'd2 ? decode_funct(funct) : ALU_NONE;
    assign is_mdu = alu_op == 2'd2 && is_mdu_funct(funct);
    assign is_mf  = ctrl == ALU_MFHI || ctrl == ALU_MFLO;
    assign slt    = $signed(fwd_a) < $signed(op_b);

    always_comb begin
        res = ctrl == ALU_ADD  ? fwd_a + op_b :
              ctrl == ALU_SUB  ? fwd_a - op_b :
              ctrl == ALU_AND  ? fwd_a & op_b :
              ctrl == ALU_OR   ? fwd_a | op_b :
              ctrl == ALU_NOR  ? ~(fwd_a | op_b) :
              ctrl == ALU_SLT  ? {{(XLEN-1){1'b0}}, slt} :
              ctrl == ALU_MFHI ? hi :
              ctrl == ALU_MFLO ? lo : '0;
    end

    // Only instructions that touch HI/LO wait on the MDU; everything else flows past it.
    assign stall_o = in_valid & ~flush_i & mdu_busy_o & (is_mdu | is_mf);
    assign bubble  = ~in_valid | flush_i | stall_o;
    assign keep    = ~bubble & ~is_mdu;

    mdu_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (~bubble & is_mdu),
        .op    (funct[1:0]),
        .a     (fwd_a),
        .b     (fwd_b),
        .busy  (mdu_busy_o),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            write_reg_q  <= '0;
            store_data_q <= '0;
            m_q          <= '0;
            wb_q         <= '0;
        end else begin
            valid_q      <= ~bubble;
            res_q        <= keep ? res : '0;
            zero_q       <= keep & ~|res;
            write_reg_q  <= keep ? dst : '0;
            store_data_q <= keep ? fwd_b : '0;
            m_q          <= keep ? m_ex : '0;
            wb_q         <= keep ? wb_ex : '0;
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: self-checking bench for ex_stage_mdu with a behavioural ALU/MDU reference model.
module tb_ex_stage_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush_i = 1'b0, alu_src = 1'b0, reg_dst = 1'b0, reg_write_wb = 1'b0;
    logic [31:0] data_1 = '0, data_2 = '0, imm = '0, wb_data = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, rd_wb = '0;
    logic [1:0]  alu_op = '0, wb_ex = '0;
    logic [2:0]  m_ex = '0;
    logic        stall_o, valid_q, zero_q, mdu_busy_o;
    logic [31:0] res_q, store_data_q;
    logic [4:0]  write_reg_q;
    logic [2:0]  m_q;
    logic [1:0]  wb_q;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    ex_stage_mdu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush_i(flush_i),
        .data_1(data_1), .data_2(data_2), .imm(imm), .rs(rs), .rt(rt), .rd(rd),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .m_ex(m_ex), .wb_ex(wb_ex),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .wb_data(wb_data),
        .stall_o(stall_o), .valid_q(valid_q), .res_q(res_q), .zero_q(zero_q),
        .write_reg_q(write_reg_q), .store_data_q(store_data_q), .m_q(m_q), .wb_q(wb_q),
        .mdu_busy_o(mdu_busy_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] s, t, d,
                         input logic [31:0] a, b);
        in_valid = 1'b1; flush_i = 1'b0; alu_op = op; alu_src = 1'b0; reg_dst = 1'b1;
        imm = {26'd0, fn}; rs = s; rt = t; rd = d; data_1 = a; data_2 = b;
        m_ex = 3'd0; wb_ex = 2'b01; rd_wb = 5'd0; reg_write_wb = 1'b0; wb_data = '0;
    endtask

    task automatic wait_busy(output int k);
        k = 0;
        while (mdu_busy_o && k < 200) begin
            tick;
            if (mdu_busy_o) k++;
        end
    endtask

    // n = number of sampled cycles with mdu_busy_o high
    task automatic run_mdu(input logic [5:0] fn, input logic [31:0] a, b, output int n);
        int k;
        in_valid = 1'b0;
        tick;
        drive(2'd2, fn, 5'd1, 5'd2, 5'd0, a, b);
        tick;
        in_valid = 1'b0;
        n = mdu_busy_o ? 1 : 0;
        wait_busy(k);
        n += k;
    endtask

    task automatic read_mf(input logic [5:0] fn, output logic [31:0] v);
        drive(2'd2, fn, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0);
        tick;
        v = res_q;
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] mdu_model(input logic [5:0] fn, input logic [31:0] a, b);
        longint sa, sb;
        if (fn == 6'd24) return 64'(longint'($signed(a)) * longint'($signed(b)));
        if (fn == 6'd25) return {32'd0, a} * {32'd0, b};
        sa = (fn == 6'd26) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (fn == 6'd26) ? longint'($signed(b)) : longint'({32'd0, b});
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic test_reset;
        int n;
        logic [31:0] v;
        repeat (2) tick;
        rst_n = 1'b1;
        checks++;
        if ({valid_q, res_q, zero_q, write_reg_q, store_data_q, m_q, wb_q, mdu_busy_o, stall_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b res=%h busy=%b required all zero", valid_q, res_q, mdu_busy_o);
        end
        run_mdu(6'd27, 32'd7, 32'd0, n);
        drive(2'd2, 6'd24, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4);
        tick;
        drive(2'd2, 6'd32, 5'd5, 5'd6, 5'd7, 32'd5, 32'd7);
        tick;
        in_valid = 1'b0;
        checks++;
        if (res_q !== 32'd12 || mdu_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got res=%h busy=%b required 0000000c 1", res_q, mdu_busy_o);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_q, res_q, zero_q, write_reg_q, store_data_q, m_q, wb_q, mdu_busy_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b res=%h wr=%h wb=%b busy=%b required all zero",
                     valid_q, res_q, write_reg_q, wb_q, mdu_busy_o);
        end
        #2 rst_n = 1'b1;
        tick;
        read_mf(6'd16, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h required 00000000", v); end
        read_mf(6'd18, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h required 00000000", v); end
    endtask

    task automatic test_back_to_back;
        drive(2'd2, 6'd32, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick;
        checks++;
        if (res_q !== 32'd12 || write_reg_q !== 5'd3 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL b2b_add: got res=%h wr=%0d required 0000000c 3", res_q, write_reg_q);
        end
        drive(2'd1, 6'd0, 5'd3, 5'd0, 5'd4, 32'd0, 32'd0);
        alu_src = 1'b1; imm = 32'd2;
        tick;
        checks++;
        if (res_q !== 32'd10) begin errors++; $display("FAIL b2b_mem_fwd: got %h required 0000000a", res_q); end
        drive(2'd2, 6'd37, 5'd3, 5'd6, 5'd5, 32'd0, 32'd1);
        rd_wb = 5'd3; reg_write_wb = 1'b1; wb_data = 32'd12;
        tick;
        checks++;
        if (res_q !== 32'd13) begin errors++; $display("FAIL b2b_wb_fwd: got %h required 0000000d", res_q); end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_guard;
        drive(2'd2, 6'd32, 5'd1, 5'd2, 5'd0, 32'd40, 32'd60);
        tick;
        drive(2'd2, 6'd32, 5'd0, 5'd1, 5'd5, 32'd9, 32'd0);
        rd_wb = 5'd0; reg_write_wb = 1'b1; wb_data = 32'd55;
        tick;
        checks++;
        if (res_q !== 32'd9) begin errors++; $display("FAIL zero_reg_guard: got %h required 00000009", res_q); end
        in_valid = 1'b0;
    endtask

    task automatic test_mult;
        int n, k;
        logic [31:0] v;
        in_valid = 1'b0;
        tick;
        drive(2'd2, 6'd24, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFD, 32'd4);
        tick;
        n = mdu_busy_o ? 1 : 0;
        checks++;
        if (mdu_busy_o !== 1'b1 || valid_q !== 1'b1 || wb_q !== 2'd0) begin
            errors++;
            $display("FAIL mult_issue: got busy=%b valid=%b wb=%b required 1 1 00", mdu_busy_o, valid_q, wb_q);
        end
        drive(2'd2, 6'd18, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL mflo_stall: got %b required 1", stall_o); end
        tick;
        if (mdu_busy_o) n++;
        checks++;
        if (valid_q !== 1'b0) begin errors++; $display("FAIL mflo_bubble: got valid=%b required 0", valid_q); end
        drive(2'd2, 6'd32, 5'd3, 5'd4, 5'd5, 32'd20, 32'd22);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL add_no_stall: got %b required 0", stall_o); end
        tick;
        if (mdu_busy_o) n++;
        checks++;
        if (res_q !== 32'd42 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL add_while_busy: got res=%h valid=%b required 0000002a 1", res_q, valid_q);
        end
        in_valid = 1'b0;
        wait_busy(k);
        n += k;
        checks++;
        if (n != 32 || mdu_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mult_busy_cycles: got %0d (busy=%b) required 32", n, mdu_busy_o);
        end
        read_mf(6'd18, v);
        checks++;
        if (v !== 32'hFFFF_FFF4) begin errors++; $display("FAIL mult_lo: got %h required fffffff4", v); end
        read_mf(6'd16, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h required ffffffff", v); end
    endtask

    task automatic test_div;
        int n;
        logic [31:0] v;
        run_mdu(6'd26, 32'hFFFF_FFF9, 32'd2, n);
        checks++;
        if (n != 32) begin errors++; $display("FAIL div_cycles: got %0d required 32", n); end
        read_mf(6'd18, v);
        checks++;
        if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h required fffffffd", v); end
        read_mf(6'd16, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h required ffffffff", v); end
        run_mdu(6'd27, 32'd7, 32'd0, n);
        checks++;
        if (n != 32) begin errors++; $display("FAIL divu0_cycles: got %0d required 32", n); end
        read_mf(6'd18, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h required ffffffff", v); end
        read_mf(6'd16, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL divu0_hi: got %h required 00000007", v); end
    endtask

    task automatic test_random_alu;
        logic [5:0]  fns [12] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd16, 6'd18, 6'd0, 6'd7, 6'd63, 6'd33};
        logic [31:0] m_hi = 32'd7, m_lo = 32'hFFFF_FFFF;
        logic        pv, pw, acc;
        logic [4:0]  pd, dst;
        logic [31:0] pres, fa, fb, ob, r;
        logic [5:0]  fn;
        in_valid = 1'b0;
        tick;
        pv = 1'b0; pw = 1'b0; pd = '0; pres = '0;
        for (int i = 0; i < 200; i++) begin
            fn = fns[$urandom_range(0, 11)];
            alu_op = 2'($urandom_range(0, 2));
            in_valid = $urandom_range(0, 9) != 0;
            flush_i = $urandom_range(0, 9) == 0;
            alu_src = 1'($urandom); reg_dst = 1'($urandom);
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
            data_1 = $urandom; data_2 = $urandom; imm = $urandom; imm[5:0] = fn;
            m_ex = 3'($urandom); wb_ex = 2'($urandom);
            rd_wb = 5'($urandom_range(0, 3)); reg_write_wb = 1'($urandom); wb_data = $urandom;
            fa = (pv && pw && pd != 0 && pd == rs) ? pres : (reg_write_wb && rd_wb != 0 && rd_wb == rs) ? wb_data : data_1;
            fb = (pv && pw && pd != 0 && pd == rt) ? pres : (reg_write_wb && rd_wb != 0 && rd_wb == rt) ? wb_data : data_2;
            ob = alu_src ? imm : fb;
            if (alu_op == 2'd0) r = fa + ob;
            else if (alu_op == 2'd1) r = fa - ob;
            else if (fn == 6'd32) r = fa + ob;
            else if (fn == 6'd34) r = fa - ob;
            else if (fn == 6'd36) r = fa & ob;
            else if (fn == 6'd37) r = fa | ob;
            else if (fn == 6'd39) r = ~(fa | ob);
            else if (fn == 6'd42) r = ($signed(fa) < $signed(ob)) ? 32'd1 : 32'd0;
            else if (fn == 6'd16) r = m_hi;
            else if (fn == 6'd18) r = m_lo;
            else r = 32'd0;
            acc = in_valid && !flush_i;
            dst = reg_dst ? rd : rt;
            tick;
            checks++;
            if (acc && {valid_q, res_q, zero_q, write_reg_q, store_data_q, m_q, wb_q} !==
                       {1'b1, r, r == 0, dst, fb, m_ex, wb_ex}) begin
                errors++;
                $display("FAIL rand_alu[%0d]: got v=%b res=%h z=%b wr=%0d sd=%h m=%h wb=%h required 1 %h %b %0d %h %h %h",
                         i, valid_q, res_q, zero_q, write_reg_q, store_data_q, m_q, wb_q, r, r == 0, dst, fb, m_ex, wb_ex);
            end else if (!acc && {valid_q, m_q, wb_q} !== '0) begin
                errors++;
                $display("FAIL rand_bubble[%0d]: got v=%b m=%h wb=%h required 0 0 0", i, valid_q, m_q, wb_q);
            end
            pv = acc; pw = acc && wb_ex[0]; pd = dst; pres = r;
        end
        in_valid = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_flush;
        int n, k;
        logic [31:0] v;
        in_valid = 1'b0;
        tick;
        drive(2'd2, 6'd27, 5'd1, 5'd2, 5'd0, 32'd50, 32'd3);
        flush_i = 1'b1;
        tick;
        in_valid = 1'b0; flush_i = 1'b0;
        checks++;
        if (valid_q !== 1'b0 || mdu_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_divu: got valid=%b busy=%b required 0 0", valid_q, mdu_busy_o);
        end
        read_mf(6'd16, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL flush_hi_kept: got %h required 00000007", v); end
        drive(2'd2, 6'd27, 5'd1, 5'd2, 5'd0, 32'd100, 32'd7);
        tick;
        n = mdu_busy_o ? 1 : 0;
        drive(2'd0, 6'd32, 5'd3, 5'd4, 5'd5, 32'd1, 32'd1);
        flush_i = 1'b1;
        tick;
        if (mdu_busy_o) n++;
        in_valid = 1'b0; flush_i = 1'b0;
        checks++;
        if (valid_q !== 1'b0 || mdu_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_while_busy: got valid=%b busy=%b required 0 1", valid_q, mdu_busy_o);
        end
        wait_busy(k);
        n += k;
        checks++;
        if (n != 32) begin errors++; $display("FAIL flush_busy_cycles: got %0d required 32", n); end
        read_mf(6'd18, v);
        checks++;
        if (v !== 32'd14) begin errors++; $display("FAIL flush_div_lo: got %h required 0000000e", v); end
        read_mf(6'd16, v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL flush_div_hi: got %h required 00000002", v); end
    endtask

    task automatic test_random_mdu;
        int n;
        logic [5:0]  fn;
        logic [31:0] a, b, vl, vh;
        logic [63:0] e;
        for (int i = 0; i < 10; i++) begin
            fn = 6'(24 + $urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            e = mdu_model(fn, a, b);
            run_mdu(fn, a, b, n);
            read_mf(6'd18, vl);
            read_mf(6'd16, vh);
            checks++;
            if (n != 32 || vl !== e[31:0] || vh !== e[63:32]) begin
                errors++;
                $display("FAIL rand_mdu[%0d] fn=%0d a=%h b=%h: got cycles=%0d hi=%h lo=%h required 32 %h %h",
                         i, fn, a, b, n, vh, vl, e[63:32], e[31:0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_zero_guard;
        test_mult;
        test_div;
        test_random_alu;
        test_flush;
        test_random_mdu;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
